// File: rtl/bram_stream_reader.sv
// Reads a run of consecutive 32-bit words through a native BRAM initiator port
// and presents them on a valid/ready stream with a last marker.
module bram_stream_reader #(
  parameter int ADDR_W     = 14,
  parameter int DATA_W     = 32,
  parameter int RD_LAT     = 1,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              abort,
  input  logic [ADDR_W-3:0] base_word,
  input  logic [ADDR_W-2:0] num_words,
  output logic              busy,
  output logic              done,
  output logic              aborted,
  output logic              bram_en,
  output logic [3:0]        bram_we,
  output logic [ADDR_W-1:0] bram_addr,
  output logic [DATA_W-1:0] bram_din,
  input  logic [DATA_W-1:0] bram_dout,
  output logic [DATA_W-1:0] m_tdata,
  output logic              m_tvalid,
  input  logic              m_tready,
  output logic              m_tlast
);
  localparam int WI_W  = ADDR_W - 2;
  localparam int REM_W = ADDR_W - 1;
  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int OCC_W = CNT_W + 1;

  typedef enum logic [2:0] {IDLE, READ, DRAIN, FIN, FLUSH} state_t;

  state_t            state;
  logic [WI_W-1:0]   word_idx;
  logic [REM_W-1:0]  remaining;
  logic [1:0]        flush_cnt;
  logic [RD_LAT-1:0] rd_vld_p;
  logic [RD_LAT-1:0] rd_lst_p;
  logic [DATA_W-1:0] fifo_data [FIFO_DEPTH];
  logic              fifo_last [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [CNT_W-1:0]  fifo_cnt;
  logic [OCC_W-1:0]  inflight;
  logic [OCC_W-1:0]  occ;
  logic              issue;
  logic              push;
  logic              pop;
  logic              abort_hit;
  logic              head_last;

  function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(FIFO_DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  // Issue stage: a read is granted only when its word is guaranteed a FIFO slot
  always_comb begin
    inflight = '0;
    for (int i = 0; i < RD_LAT; i++) inflight = inflight + OCC_W'(rd_vld_p[i]);
    occ       = OCC_W'(fifo_cnt) + inflight;
    abort_hit = abort && (state == READ || state == DRAIN);
    issue     = (state == READ) && !abort && (remaining != '0) &&
                (occ < OCC_W'(FIFO_DEPTH));
    push      = rd_vld_p[RD_LAT-1] && (state != FLUSH);
    m_tvalid  = (fifo_cnt != '0);
    pop       = m_tvalid && m_tready;
    head_last = fifo_last[rd_ptr];
    m_tdata   = m_tvalid ? fifo_data[rd_ptr] : '0;
    m_tlast   = m_tvalid && head_last;
  end

  assign bram_en   = issue;
  assign bram_addr = {word_idx, 2'b00};
  assign bram_we   = '0;
  assign bram_din  = '0;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      aborted   <= 1'b0;
      word_idx  <= '0;
      remaining <= '0;
      flush_cnt <= '0;
    end else begin
      done    <= 1'b0;
      aborted <= 1'b0;
      case (state)
        IDLE: if (start) begin
          word_idx  <= base_word;
          remaining <= num_words;
          busy      <= 1'b1;
          state     <= (num_words == '0) ? FIN : READ;
        end
        READ: if (abort) begin
          flush_cnt <= '0;
          state     <= FLUSH;
        end else if (issue) begin
          word_idx  <= word_idx + WI_W'(1);
          remaining <= remaining - REM_W'(1);
          if (remaining == REM_W'(1)) state <= DRAIN;
        end
        DRAIN: if (abort) begin
          flush_cnt <= '0;
          state     <= FLUSH;
        end else if (pop && head_last) begin
          // done must follow the tlast handshake by exactly one cycle
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= IDLE;
        end
        FIN: begin
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= IDLE;
        end
        FLUSH: if (flush_cnt == 2'(RD_LAT - 1)) begin
          aborted <= 1'b1;
          busy    <= 1'b0;
          state   <= IDLE;
        end else begin
          flush_cnt <= flush_cnt + 2'd1;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Return stage: in-flight valid bits emerge RD_LAT cycles after bram_en
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_vld_p <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fifo_cnt <= '0;
    end else begin
      rd_vld_p <= (rd_vld_p << 1) | RD_LAT'(issue);
      if (abort_hit) begin
        wr_ptr   <= '0;
        rd_ptr   <= '0;
        fifo_cnt <= '0;
      end else begin
        if (push) wr_ptr <= ptr_next(wr_ptr);
        if (pop)  rd_ptr <= ptr_next(rd_ptr);
        fifo_cnt <= fifo_cnt + CNT_W'(push) - CNT_W'(pop);
      end
    end
  end

  // FIFO stage: payload storage, qualified entirely by the control above
  always_ff @(posedge clk) begin
    rd_lst_p <= (rd_lst_p << 1) | RD_LAT'(issue && (remaining == REM_W'(1)));
    if (push) begin
      fifo_data[wr_ptr] <= bram_dout;
      fifo_last[wr_ptr] <= rd_lst_p[RD_LAT-1];
    end
  end

endmodule
